// File: rtl/sdmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, answered after LATENCY wait cycles.
// Optional macro SDMEM_MISALIGN_CHECK_EN rejects misaligned halves/words and the reserved size.
module sdmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the request side is ready only in IDLE, the response is held until rsp_ready.

    localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic [ADDR_WIDTH-3:0]   widx;
    logic [31:0]             rd_word;
    logic [1:0]              size_eff;
    logic                    req_bad;
    logic [3:0]              be;
    logic [31:0]             wdata_lane;
    logic [31:0]             load_val;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;

    assign accept  = req_valid & req_ready;
    assign widx    = req_addr[ADDR_WIDTH-1:2];
    assign rd_word = mem[widx];

`ifdef SDMEM_MISALIGN_CHECK_EN
    assign req_bad = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));
`else
    assign req_bad = 1'b0;
`endif

    // The reserved size behaves as a word whenever it is not rejected.
    assign size_eff = (req_size == 2'b11) ? 2'b10 : req_size;
    assign rd_byte  = rd_word[{req_addr[1:0], 3'b000} +: 8];
    assign rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = req_wdata;
        load_val   = rd_word;
        case (size_eff)
            2'b00: begin
                be         = 4'b0001 << req_addr[1:0];
                wdata_lane = {4{req_wdata[7:0]}};
                load_val   = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                be         = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{req_wdata[15:0]}};
                load_val   = {{16{~req_unsigned & rd_half[15]}}, rd_half};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = req_wdata;
                load_val   = rd_word;
            end
        endcase
    end

    // Array is not reset; a store committed at acceptance survives a later reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                rsp_rdata <= (req_write || req_bad) ? '0 : load_val;
                rsp_err   <= req_bad;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdmem_responder.sv
// Self-checking bench for sdmem_responder: byte-level reference model feeding a scoreboard queue.
// Honours SDMEM_MISALIGN_CHECK_EN when the same macro is defined for the build.
module tb_sdmem_responder;
    localparam int AW  = 12;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    sdmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // clock / reset-time counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: expected {err, rdata} and acceptance cycle per request
    logic [32:0] exp_q[$];
    int          lat_q[$];
    logic [32:0] last_rsp = '0;
    int          n_total = 0;
    int          n_bad = 0;
    logic [7:0]  mem_b [1 << AW];
    logic        force_rdy = 1'b0;
    logic        rdy_val = 1'b1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference model: byte-addressed memory, sizes as byte counts
    function automatic logic [32:0] model_req(input logic wr, input logic [AW-1:0] a,
                                              input logic [1:0] sz, input logic uns,
                                              input logic [31:0] wd);
        int n;
        int base;
        logic bad;
        logic [31:0] v;
        bad = 1'b0;
`ifdef SDMEM_MISALIGN_CHECK_EN
        bad = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`endif
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a) - (int'(a) % n);
        if (bad) return {1'b1, 32'h0};
        if (wr) begin
            for (int i = 0; i < n; i++) mem_b[base + i] = wd[8*i +: 8];
            return 33'h0;
        end
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[base + i];
        if (!uns && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
        return {1'b0, v};
    endfunction

    // driver: rsp_ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // driver: one request, expected result pushed at acceptance
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
        int budget = 0;
        do begin
            @(posedge clk);
            #1;
            budget++;
        end while (!req_ready && budget < 200);
        if (!req_ready) begin
            check("req_ready_timeout", {32'h0, req_ready}, 33'h1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_size = sz;
        req_unsigned = uns;
        req_wdata = wd;
        @(posedge clk);
        #1;
        exp_q.push_back(model_req(wr, a, sz, uns, wd));
        lat_q.push_back(cyc);
        req_valid = 1'b0;
        req_addr = AW'($urandom);
        req_wdata = $urandom;
        req_size = 2'($urandom);
        req_write = 1'($urandom);
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 300) begin
            @(posedge clk);
            b++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 33'(exp_q.size()), 33'h0);
    endtask

    // monitor: latency on first rsp_valid, data/err on each handshake
    initial begin
        logic prev_valid = 1'b0;
        logic [32:0] e;
        int a;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid && !prev_valid) begin
                    if (lat_q.size() == 0) begin
                        check("unexpected_valid", 33'h1, 33'h0);
                    end else begin
                        a = lat_q.pop_front();
                        check("latency", 33'(cyc), 33'(a + LAT));
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    last_rsp = {rsp_err, rsp_rdata};
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", last_rsp, 33'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", last_rsp, e);
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    end

    // main sequence
    initial begin
        int b;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {32'h0, rsp_valid}, 33'h0);
        check("rst_req_ready", {32'h0, req_ready}, 33'h1);
        check("rst_rsp_rdata", {1'b0, rsp_rdata}, 33'h0);
        check("rst_rsp_err", {32'h0, rsp_err}, 33'h0);
        rst = 1'b0;

        // fill the exercised region so every later load has defined data
        for (int i = 0; i < 64; i++) do_req(1'b1, AW'(4 * i), 2'b10, 1'b0, $urandom);
        wait_drain();

        do_req(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF);
        do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
        wait_drain();
        check("ld_word", last_rsp, {1'b0, 32'hDEADBEEF});
        do_req(1'b0, 12'h013, 2'b00, 1'b0, 32'h0);
        wait_drain();
        check("ld_byte_s", last_rsp, {1'b0, 32'hFFFFFFDE});
        do_req(1'b0, 12'h013, 2'b00, 1'b1, 32'h0);
        wait_drain();
        check("ld_byte_u", last_rsp, {1'b0, 32'h000000DE});
        do_req(1'b0, 12'h010, 2'b01, 1'b0, 32'h0);
        wait_drain();
        check("ld_half_s", last_rsp, {1'b0, 32'hFFFFBEEF});
        do_req(1'b1, 12'h011, 2'b00, 1'b0, 32'h0000005A);
        do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
        wait_drain();
        check("st_byte_merge", last_rsp, {1'b0, 32'hDEAD5AEF});

        // backpressure: response held while rsp_ready is low
        force_rdy = 1'b1;
        rdy_val = 1'b0;
        do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!rsp_valid && b < 50);
        check("bp_valid_seen", {32'h0, rsp_valid}, 33'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", {32'h0, rsp_valid}, 33'h1);
            check("bp_rdata_hold", {1'b0, rsp_rdata}, {1'b0, 32'hDEAD5AEF});
            check("bp_req_ready_low", {32'h0, req_ready}, 33'h0);
        end
        rdy_val = 1'b1;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!(rsp_valid && rsp_ready) && b < 50);
        @(negedge clk);
        check("bp_idle_req_ready", {32'h0, req_ready}, 33'h1);
        check("bp_idle_rsp_valid", {32'h0, rsp_valid}, 33'h0);

        // reset while waiting on a store: response dropped, store kept
        do_req(1'b1, 12'h020, 2'b10, 1'b0, 32'h12345678);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check("midrst_rsp_valid", {32'h0, rsp_valid}, 33'h0);
        check("midrst_req_ready", {32'h0, req_ready}, 33'h1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst_rsp_valid", {32'h0, rsp_valid}, 33'h0);
        check("postrst_req_ready", {32'h0, req_ready}, 33'h1);
        do_req(1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
        wait_drain();
        check("ld_after_rst", last_rsp, {1'b0, 32'h12345678});

        // misaligned word store
        do_req(1'b1, 12'h022, 2'b10, 1'b0, 32'hCAFEF00D);
        wait_drain();
`ifdef SDMEM_MISALIGN_CHECK_EN
        check("misalign_err", last_rsp, {1'b1, 32'h0});
`else
        check("misalign_err", last_rsp, 33'h0);
`endif
        do_req(1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
        wait_drain();
`ifdef SDMEM_MISALIGN_CHECK_EN
        check("misalign_mem", last_rsp, {1'b0, 32'h12345678});
`else
        check("misalign_mem", last_rsp, {1'b0, 32'hCAFEF00D});
`endif

        // randomized traffic with random response backpressure
        force_rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end
        wait_drain();
        check("lat_q_empty", 33'(lat_q.size()), 33'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
